uart_tx_fifo: RTL

Buffered byte front-end for the UART transmitter. Accepts bytes from a host over a valid/ready interface, stores up to DEPTH of them, and drives the transmitter's start strobe and parallel byte one frame at a time, using the transmitter's active flag as the completion handshake. It sits directly upstream of uart_tx in the UART top level and shares its clock and reset.

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo.sv | 74 +++++++
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the TX FIFO front-end state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    BUSY
  } tx_fifo_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push_i        enqueue wr_data_i (ignored when full)
//   pop_i         dequeue head into rd_data_o (ignored when empty)
//   wr_data_i     write data
//   rd_data_o     registered head entry, updated only on a pop
//   count_o       number of stored entries, 0..DEPTH
//   full_o        count_o == DEPTH
//   empty_o       count_o == 0
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CNT_WIDTH'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Occupancy update; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (do_pop) begin
        rd_ptr_q  <= rd_ptr_q + ADDR_WIDTH'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage has no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered byte front-end for the UART transmitter.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   wr_valid   host offers wr_data;  wr_ready  FIFO not full
//   wr_data    byte to enqueue
//   tx_active  transmitter busy flag (completion handshake)
//   tx_drive   start strobe to transmitter, held until tx_active
//   tx_data    byte to transmitter, changes only on a pop
//   count      stored entries; empty / full derived from it
//   overflow   sticky: offer seen while full, cleared by rst
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  tx_active,
  output logic                  tx_drive,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  tx_fifo_state_t state_q;
  logic           tx_drive_q;
  logic           overflow_q;
  logic           push_c, pop_c;

  assign wr_ready = !full;
  assign push_c   = wr_valid && !full && !rst;
  // Pop from IDLE, or from BUSY once the current frame has completed.
  assign pop_c    = !empty && !rst &&
                    ((state_q == IDLE) || ((state_q == BUSY) && !tx_active));

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_c),
    .pop_i     (pop_c),
    .wr_data_i (wr_data),
    .rd_data_o (tx_data),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Frame sequencer: strobe until the transmitter answers, then wait it out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_drive_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_drive_q <= 1'b0;
          if (!empty) begin
            state_q    <= DRIVE;
            tx_drive_q <= 1'b1;
          end
        end
        DRIVE: begin
          tx_drive_q <= 1'b1;
          if (tx_active) begin
            state_q    <= BUSY;
            tx_drive_q <= 1'b0;
          end
        end
        BUSY: begin
          tx_drive_q <= 1'b0;
          if (!tx_active) begin
            if (!empty) begin
              state_q    <= DRIVE;
              tx_drive_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          tx_drive_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst)                  overflow_q <= 1'b0;
    else if (wr_valid && full) overflow_q <= 1'b1;
  end

  assign tx_drive = tx_drive_q;
  assign overflow = overflow_q;

endmodule
